// File: rtl/vga_frame_dbuf.sv
// vga_frame_dbuf: double-buffered, downscaled VGA frame store.
// Two RAM banks of DEPTH x DATA_WIDTH words. Scan-out reads the front bank
// and the drawing side writes the back bank. The back bank can be filled with
// CLEAR_VALUE by hardware. A requested swap only takes effect on frame_start,
// so the displayed image never tears.
//
// Ports:
//   clk_i          clock; all logic runs on the rising edge
//   rst_i          synchronous, active-high reset
//   data_i         write data for the back bank
//   write_addr_i   back-bank write address (out-of-range writes are dropped)
//   we_i           write enable
//   read_addr_i    front-bank read address (out-of-range reads return 0)
//   q_o            registered read data, 1-cycle latency
//   frame_start_i  one-cycle pulse at the start of vertical blanking
//   swap_req_i     one-cycle pulse: exchange banks at the next frame_start
//   clear_req_i    one-cycle pulse: fill the back bank with CLEAR_VALUE
//   front_sel_o    index of the bank currently being displayed
//   busy_o         a clear is running or a swap is pending
//   swap_done_o    one-cycle pulse after the edge on which banks swapped
//   clear_done_o   one-cycle pulse after the edge that wrote the last clear word
module vga_frame_dbuf #(
  parameter int                  DATA_WIDTH  = 2,
  parameter int                  ADDR_WIDTH  = 15,
  parameter int                  N_PIXELS    = 640*480,
  parameter int                  DIVIDER     = 4*4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] q_o,
  input  logic                  frame_start_i,
  input  logic                  swap_req_i,
  input  logic                  clear_req_i,
  output logic                  front_sel_o,
  output logic                  busy_o,
  output logic                  swap_done_o,
  output logic                  clear_done_o
);

  localparam int                  DEPTH    = N_PIXELS / DIVIDER;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  state_t                state_q,      state_d;
  logic                  swap_pend_q,  swap_pend_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q,    clr_cnt_d;
  logic                  front_sel_q,  front_sel_d;
  logic                  swap_done_q,  swap_done_d;
  logic                  clear_done_q, clear_done_d;
  logic [DATA_WIDTH-1:0] q_q;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  logic rd_ok, wr_ok;
  assign rd_ok = ({1'b0, read_addr_i}  < DEPTH_W);
  assign wr_ok = ({1'b0, write_addr_i} < DEPTH_W);

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      swap_pend_q  <= 1'b0;
      clr_cnt_q    <= '0;
      front_sel_q  <= 1'b0;
      swap_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      swap_pend_q  <= swap_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      front_sel_q  <= front_sel_d;
      swap_done_q  <= swap_done_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Next-state logic and back-bank write port steering
  always_comb begin
    state_d      = state_q;
    swap_pend_d  = swap_pend_q;
    clr_cnt_d    = clr_cnt_q;
    front_sel_d  = front_sel_q;
    swap_done_d  = 1'b0;
    clear_done_d = 1'b0;
    // External writes by default; the clear engine overrides in CLEAR.
    ram_we       = we_i & wr_ok;
    ram_addr     = write_addr_i;
    ram_wdata    = data_i;

    unique case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          swap_pend_d = swap_req_i;  // remember a swap requested alongside
        end else if (swap_req_i) begin
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = CLEAR_VALUE;
        if (clr_cnt_q == LAST_IDX) begin
          clear_done_d = 1'b1;
          state_d      = (swap_pend_q || swap_req_i) ? SWAP_WAIT : IDLE;
          swap_pend_d  = 1'b0;
          clr_cnt_d    = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (swap_req_i) swap_pend_d = 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (frame_start_i) begin
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) ram_we = 1'b0;
  end

  // Back bank is the one not selected by the registered front_sel, so a write
  // on the swap edge still lands in the bank that becomes front.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      if (front_sel_q) mem0[ram_addr] <= ram_wdata;
      else             mem1[ram_addr] <= ram_wdata;
    end
  end

  // Front-bank read, registered; uses pre-edge front_sel.
  always_ff @(posedge clk_i) begin
    if (rst_i)      q_q <= '0;
    else if (rd_ok) q_q <= front_sel_q ? mem1[read_addr_i] : mem0[read_addr_i];
    else            q_q <= '0;
  end

  assign q_o          = q_q;
  assign front_sel_o  = front_sel_q;
  assign busy_o       = (state_q != IDLE) | swap_pend_q;
  assign swap_done_o  = swap_done_q;
  assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_vga_frame_dbuf.sv
// Directed testbench for vga_frame_dbuf (CLEAR_VALUE = 3, default geometry).
module tb_vga_frame_dbuf;

  localparam int DW    = 2;
  localparam int AW    = 15;
  localparam int DEPTH = 19200;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic [AW-1:0] write_addr;
  logic          we;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] q;
  logic          frame_start, swap_req, clear_req;
  logic          front_sel, busy, swap_done, clear_done;

  int checks = 0;
  int errors = 0;

  vga_frame_dbuf #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N_PIXELS   (640*480),
    .DIVIDER    (16),
    .CLEAR_VALUE(2'd3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .write_addr_i (write_addr),
    .we_i         (we),
    .read_addr_i  (read_addr),
    .q_o          (q),
    .frame_start_i(frame_start),
    .swap_req_i   (swap_req),
    .clear_req_i  (clear_req),
    .front_sel_o  (front_sel),
    .busy_o       (busy),
    .swap_done_o  (swap_done),
    .clear_done_o (clear_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later and
  // single-cycle pulses are dropped.
  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0; frame_start = 1'b0; swap_req = 1'b0; clear_req = 1'b0; rst = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1; write_addr = AW'(a); data = DW'(d);
    tick();
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    read_addr = AW'(a);
    tick();
    chk(tag, int'(q), exp);
  endtask

  // Called right after the edge that accepted clear_req. Counts edges until
  // clear_done, bounded, optionally pulsing frame_start / a write midway.
  task automatic run_clear(input string tag, input bit fs_mid, input bit wr_mid,
                           output int n);
    bit busy_low = 1'b0;
    bit seen     = 1'b0;
    n = 0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      if (busy !== 1'b1) busy_low = 1'b1;
      if (i == 50 && fs_mid) frame_start = 1'b1;
      if (i == 60 && wr_mid) begin we = 1'b1; write_addr = AW'(5); data = 2'd1; end
      tick();
      n++;
      if (clear_done === 1'b1) begin seen = 1'b1; break; end
    end
    chk({tag, "_seen"}, int'(seen), 1);
    chk({tag, "_cycles"}, n, DEPTH);
    chk({tag, "_busy_hi"}, int'(busy_low), 0);
    tick();
    chk({tag, "_done_pulse"}, int'(clear_done), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; data = '0; write_addr = '0; we = 1'b0; read_addr = '0;
    frame_start = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_q", int'(q), 0);
    chk("rst_front", int'(front_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_swap_done", int'(swap_done), 0);
    chk("rst_clear_done", int'(clear_done), 0);

    // Clear bank1 (back) to 3; a write during the clear is dropped.
    clear_req = 1'b1;
    tick();
    chk("clr1_busy_start", int'(busy), 1);
    run_clear("clr1", 1'b0, 1'b1, n);
    chk("clr1_idle_busy", int'(busy), 0);

    // Swap: bank1 becomes front.
    swap_req = 1'b1;
    tick();
    chk("sw1_busy", int'(busy), 1);
    frame_start = 1'b1;
    tick();
    chk("sw1_done", int'(swap_done), 1);
    chk("sw1_front", int'(front_sel), 1);
    tick();
    chk("sw1_done_pulse", int'(swap_done), 0);
    rd("rd_b1_0", 0, 3);
    rd("rd_b1_5_wr_dropped", 5, 3);
    rd("rd_b1_last", DEPTH - 1, 3);
    rd("rd_oob", DEPTH, 0);

    // clear_req + swap_req together: clear bank0, then wait for frame_start.
    clear_req = 1'b1; swap_req = 1'b1;
    tick();
    run_clear("clr2", 1'b1, 1'b0, n);
    chk("clr2_front_hold", int'(front_sel), 1);
    chk("clr2_busy_wait", int'(busy), 1);
    for (int i = 0; i < 4; i++) wr(i, i);
    wr(DEPTH, 1);
    rd("pre_swap_old_front", 2, 3);
    frame_start = 1'b1;
    tick();
    chk("sw2_done", int'(swap_done), 1);
    chk("sw2_front", int'(front_sel), 0);
    rd("rd_b0_0", 0, 0);
    rd("rd_b0_1", 1, 1);
    rd("rd_b0_2", 2, 2);
    rd("rd_b0_3", 3, 3);
    rd("rd_b0_4", 4, 3);
    rd("rd_b0_oob", DEPTH, 0);

    // frame_start with nothing pending
    frame_start = 1'b1;
    tick();
    chk("fs_idle_front", int'(front_sel), 0);
    chk("fs_idle_done", int'(swap_done), 0);

    // Double swap_req -> single toggle
    swap_req = 1'b1; tick();
    swap_req = 1'b1; tick();
    frame_start = 1'b1; tick();
    chk("dbl_front", int'(front_sel), 1);
    frame_start = 1'b1; tick();
    chk("dbl_front_again", int'(front_sel), 1);
    chk("dbl_done", int'(swap_done), 0);
    chk("dbl_busy", int'(busy), 0);

    // Swap-edge read returns old front; swap-edge write lands in new front.
    swap_req = 1'b1; tick();
    frame_start = 1'b1; read_addr = AW'(1);
    we = 1'b1; write_addr = AW'(10); data = 2'd2;
    tick();
    chk("edge_rd_old_front", int'(q), 3);
    chk("edge_front", int'(front_sel), 0);
    rd("edge_wr_landed", 10, 2);
    rd("edge_rd_new_front", 1, 1);

    // Reset mid-clear, then a fresh clear restarts from zero.
    swap_req = 1'b1; tick();
    frame_start = 1'b1; tick();
    chk("pre_rst_front", int'(front_sel), 1);
    read_addr = AW'(0);
    clear_req = 1'b1;
    tick();
    repeat (100) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_front", int'(front_sel), 0);
    chk("mid_rst_q", int'(q), 0);
    chk("mid_rst_clear_done", int'(clear_done), 0);
    tick();
    chk("post_rst_clear_done", int'(clear_done), 0);
    clear_req = 1'b1;
    tick();
    run_clear("clr3", 1'b0, 1'b0, n);
    chk("clr3_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
